// File: rtl/rom_read_arbiter_if.sv
// Bus bundle for rom_read_arbiter: pass control, per-lane request inputs,
// ROM strobe/address, FIFO write strobes and status.
interface rom_read_arbiter_if #(
  parameter int unsigned array_size = 9,
  parameter int unsigned addr_width = 20
);
  logic                             start;
  logic                             enable;
  logic [array_size-1:0]            lane_req;
  logic [array_size-1:0]            lane_full;
  logic [array_size-1:0]            lane_last;
  logic [array_size*addr_width-1:0] lane_addr;
  logic [addr_width-1:0]            rom_addr;
  logic                             rom_en;
  logic [array_size-1:0]            grant;
  logic [array_size-1:0]            write_enable_out;
  logic                             busy;
  logic                             completed;
  logic [1:0]                       state;

  modport slave (
    input  start, enable, lane_req, lane_full, lane_last, lane_addr,
    output rom_addr, rom_en, grant, write_enable_out, busy, completed, state
  );

  modport master (
    output start, enable, lane_req, lane_full, lane_last, lane_addr,
    input  rom_addr, rom_en, grant, write_enable_out, busy, completed, state
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one ROM read port between FIFO lanes; a tag
// pipeline turns each grant into a FIFO write strobe aligned with ROM data.
module rom_read_arbiter #(
  parameter int unsigned array_size  = 9,
  parameter int unsigned addr_width  = 20,
  parameter int unsigned rom_latency = 2
) (
  input  logic                clk,
  input  logic                reset,
  rom_read_arbiter_if.slave   bus
);

  localparam int unsigned PTR_W = (array_size > 1) ? $clog2(array_size) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [array_size-1:0]  lane_done_q, lane_done_d;
  logic [array_size-1:0]  grant_q, grant_d;
  logic [addr_width-1:0]  rom_addr_q, rom_addr_d;
  logic                   rom_en_q, rom_en_d;
  logic                   completed_q, completed_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [array_size-1:0]  tag_q [rom_latency];
  logic [array_size-1:0]  tag_d [rom_latency];

  logic [array_size-1:0]  eligible;
  logic                   found;
  logic [PTR_W-1:0]       sel;
  logic                   in_flight;

  // grant_q in the mask keeps a lane from being granted on back-to-back cycles.
  always_comb begin : select_p
    int unsigned idx;
    idx      = 0;
    found    = 1'b0;
    sel      = ptr_q;
    eligible = '0;
    if (state_q == ARB && bus.enable) begin
      eligible = bus.lane_req & ~bus.lane_full & ~lane_done_q & ~grant_q;
    end
    for (int unsigned i = 0; i < array_size; i++) begin
      idx = ptr_q + i;
      if (idx >= array_size) begin
        idx = idx - array_size;
      end
      if (!found && eligible[PTR_W'(idx)]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

  // A word is still in flight if it sits in grant_q or any tag stage that
  // has not yet reached the output stage.
  always_comb begin
    in_flight = |grant_q;
    for (int unsigned i = 0; i + 1 < rom_latency; i++) begin
      in_flight = in_flight | (|tag_q[i]);
    end
  end

  always_comb begin
    tag_d[0] = grant_q;
    for (int unsigned i = 1; i < rom_latency; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_done_d = lane_done_q;
    completed_d = completed_q;
    ptr_d       = ptr_q;
    rom_addr_d  = rom_addr_q;
    rom_en_d    = 1'b0;
    grant_d     = '0;

    if (found) begin
      grant_d[sel]     = 1'b1;
      rom_en_d         = 1'b1;
      rom_addr_d       = bus.lane_addr[sel*addr_width +: addr_width];
      lane_done_d[sel] = bus.lane_last[sel];
      ptr_d            = (sel == PTR_W'(array_size - 1)) ? '0 : sel + 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = ARB;
          lane_done_d = '0;
          completed_d = 1'b0;
        end
      end
      ARB: begin
        if (bus.enable && (&lane_done_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.enable && !in_flight) begin
          state_d     = DONE;
          completed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lane_done_q <= '0;
      completed_q <= 1'b0;
      ptr_q       <= '0;
      rom_addr_q  <= '0;
      rom_en_q    <= 1'b0;
      grant_q     <= '0;
      tag_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      lane_done_q <= lane_done_d;
      completed_q <= completed_d;
      ptr_q       <= ptr_d;
      rom_addr_q  <= rom_addr_d;
      rom_en_q    <= rom_en_d;
      grant_q     <= grant_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.rom_addr         = rom_addr_q;
  assign bus.rom_en           = rom_en_q;
  assign bus.grant            = grant_q;
  assign bus.write_enable_out = tag_q[rom_latency-1];
  assign bus.completed        = completed_q;
  assign bus.state            = state_q;
  assign bus.busy             = (state_q == ARB) || (state_q == DRAIN);

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed scenarios for rom_read_arbiter; expected grants are queued by the
// stimulus and consumed by a monitor that checks grants and FIFO strobes.
module tb_rom_read_arbiter;

  localparam int unsigned N   = 9;
  localparam int unsigned AW  = 20;
  localparam int unsigned LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rom_read_arbiter_if #(.array_size(N), .addr_width(AW)) bus ();

  rom_read_arbiter #(
    .array_size (N),
    .addr_width (AW),
    .rom_latency(LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int unsigned     lane;
    logic [AW-1:0]   addr;
  } gexp_t;

  gexp_t       gq[$];
  int unsigned wq[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  int unsigned seq_d [16] = '{4, 5, 6, 7, 8, 0, 1, 3, 4, 5, 6, 7, 8, 0, 1, 2};
  int unsigned seq_e [6]  = '{3, 4, 5, 6, 7, 8};

  function automatic logic [N-1:0] onehot(input int unsigned k);
    return N'(1) << k;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int unsigned lane, input bit with_weo);
    gexp_t g;
    g.lane = lane;
    g.addr = AW'(lane * 16);
    gq.push_back(g);
    if (with_weo) wq.push_back(lane);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: grants and strobes against queued expectations, plus the
  // strobe-to-grant latency against the grant history seen at the outputs.
  initial begin : monitor
    logic [N-1:0] h1, h2;
    gexp_t        g;
    int unsigned  wl;
    h1 = '0;
    h2 = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        h1 = '0;
        h2 = '0;
      end else begin
        if (bus.rom_en) begin
          if (gq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_unexpected: got grant 0x%0h, expected none (t=%0t)", bus.grant, $time);
          end else begin
            g = gq.pop_front();
            check("grant", 32'(bus.grant), 32'(onehot(g.lane)));
            check("rom_addr", 32'(bus.rom_addr), 32'(g.addr));
          end
        end else if (bus.grant != '0) begin
          check("grant_without_rom_en", 32'(bus.grant), 32'd0);
        end
        if (bus.write_enable_out != '0) begin
          if (wq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL weo_unexpected: got 0x%0h, expected none (t=%0t)", bus.write_enable_out, $time);
          end else begin
            wl = wq.pop_front();
            check("weo_lane", 32'(bus.write_enable_out), 32'(onehot(wl)));
          end
        end
        if ((bus.write_enable_out | h2) != '0) begin
          check("weo_latency", 32'(bus.write_enable_out), 32'(h2));
        end
        h2 = h1;
        h1 = bus.grant;
      end
    end
  end

  initial begin : stimulus
    int unsigned cnt [N];
    int unsigned total;
    int unsigned k;

    bus.start     = 1'b0;
    bus.enable    = 1'b1;
    bus.lane_req  = '0;
    bus.lane_full = '0;
    bus.lane_last = '0;
    bus.lane_addr = '0;
    for (int i = 0; i < int'(N); i++) bus.lane_addr[i*AW +: AW] = AW'(i * 16);

    // Reset state, then idle hold without start
    #12;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_rom_en", 32'(bus.rom_en), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_completed", 32'(bus.completed), 32'd0);
    reset = 1'b1;
    tick(3);
    check("idle_hold", 32'(bus.state), 32'd0);

    // A: all lanes requesting, round robin from lane 0
    for (int i = 0; i < 12; i++) push(i % 9, 1'b1);
    bus.lane_req = '1;
    bus.start    = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("a_state_arb", 32'(bus.state), 32'd1);
    tick(12);

    // B: only lane 3 requesting -> every other cycle
    bus.lane_req = onehot(3);
    for (int i = 0; i < 3; i++) push(3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("b_rom_en_pattern", 32'(bus.rom_en), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.lane_req = '0;
    tick(3);

    // start while in ARB is ignored
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("start_ignored_state", 32'(bus.state), 32'd1);
    check("start_ignored_busy", 32'(bus.busy), 32'd1);

    // D: lane 2 full for 10 cycles
    for (int i = 0; i < 16; i++) push(seq_d[i], 1'b1);
    bus.lane_req  = '1;
    bus.lane_full = onehot(2);
    tick(10);
    bus.lane_full = '0;
    tick(6);
    bus.lane_req = '0;
    tick(3);

    // E: enable low for 5 cycles mid-stream
    for (int i = 0; i < 6; i++) push(seq_e[i], 1'b1);
    bus.lane_req = '1;
    tick(3);
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("e_no_grant", 32'(bus.rom_en), 32'd0);
      check("e_state_hold", 32'(bus.state), 32'd1);
    end
    bus.enable = 1'b1;
    tick(3);
    bus.lane_req = '0;
    tick(3);

    // C: every lane marks its 4th word as last -> 36 grants, drain, done
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < int'(N); i++) push(i, 1'b1);
    for (int i = 0; i < int'(N); i++) cnt[i] = 0;
    total = 0;
    bus.lane_req = '1;
    for (int c = 0; c < 200 && total < 36; c++) begin
      tick(1);
      if (bus.grant != '0) begin
        k = 0;
        for (int i = 0; i < int'(N); i++) if (bus.grant[i]) k = i;
        cnt[k]++;
        total++;
        if (cnt[k] == 3) bus.lane_last[k] = 1'b1;
      end
    end
    check("c_grant_total", total, 32'd36);
    bus.lane_req  = '0;
    bus.lane_last = '0;
    check("c_arb_at_last", 32'(bus.state), 32'd1);
    tick(1);
    check("c_drain1", 32'(bus.state), 32'd2);
    tick(1);
    check("c_drain2", 32'(bus.state), 32'd2);
    tick(1);
    check("c_done_state", 32'(bus.state), 32'd3);
    check("c_completed", 32'(bus.completed), 32'd1);
    check("c_done_busy", 32'(bus.busy), 32'd0);
    tick(2);
    check("c_done_hold", 32'(bus.completed), 32'd1);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("c_restart_state", 32'(bus.state), 32'd1);
    check("c_restart_completed", 32'(bus.completed), 32'd0);

    // F: reset while two tags are in flight
    push(0, 1'b0);
    push(1, 1'b0);
    bus.lane_req = '1;
    tick(2);
    bus.lane_req = '0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("f_state", 32'(bus.state), 32'd0);
    check("f_rom_en", 32'(bus.rom_en), 32'd0);
    check("f_grant", 32'(bus.grant), 32'd0);
    check("f_weo", 32'(bus.write_enable_out), 32'd0);
    check("f_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("f_busy", 32'(bus.busy), 32'd0);
    check("f_completed", 32'(bus.completed), 32'd0);
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("f_idle_after_reset", 32'(bus.state), 32'd0);
    end

    check("grant_queue_empty", gq.size(), 32'd0);
    check("weo_queue_empty", wq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
